// File: rtl/i2s_rx.sv
// I2S capture path: oversamples the asynchronous codec pins on clk and delivers
// each complete left/right pair as parallel signed samples with a one-cycle strobe.
module i2s_rx #(
  parameter int BITSIZE = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bclk,
  input  logic               lrclk,
  input  logic               sdata,
  output logic [BITSIZE-1:0] left_chan,
  output logic [BITSIZE-1:0] right_chan,
  output logic               valid,
  output logic               frame_err
);

  localparam int CNT_W = $clog2(BITSIZE + 1);

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  logic               bclk_sync1_r;
  logic               bclk_sync2_r;
  logic               bclk_sync3_r;
  logic               lrclk_sync1_r;
  logic               lrclk_sync2_r;
  logic               sdata_sync1_r;
  logic               sdata_sync2_r;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [BITSIZE-1:0] shift_r;
  logic [BITSIZE-1:0] hold_r;
  logic               lr_prev_r;
  logic               chan_r;
  logic               left_ok_r;

  logic               rise_s;
  logic               lr_s;
  logic               d_s;
  logic               edge_s;
  logic [CNT_W-1:0]   cnt_next_s;
  logic               word_done_s;
  logic [BITSIZE-1:0] word_s;

  // Two-flop synchronisers on all pins; a third bclk stage gives rise detection.
  // lrclk/sdata share bclk's depth so they are captured with the rise they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_sync1_r  <= 1'b0;
      bclk_sync2_r  <= 1'b0;
      bclk_sync3_r  <= 1'b0;
      lrclk_sync1_r <= 1'b0;
      lrclk_sync2_r <= 1'b0;
      sdata_sync1_r <= 1'b0;
      sdata_sync2_r <= 1'b0;
    end else begin
      bclk_sync1_r  <= bclk;
      bclk_sync2_r  <= bclk_sync1_r;
      bclk_sync3_r  <= bclk_sync2_r;
      lrclk_sync1_r <= lrclk;
      lrclk_sync2_r <= lrclk_sync1_r;
      sdata_sync1_r <= sdata;
      sdata_sync2_r <= sdata_sync1_r;
    end
  end

  // Per-rise decode: word-select edge detection and the next shift-register value.
  always_comb begin
    rise_s      = bclk_sync2_r & ~bclk_sync3_r;
    lr_s        = lrclk_sync2_r;
    d_s         = sdata_sync2_r;
    edge_s      = lr_s ^ lr_prev_r;
    cnt_next_s  = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    word_done_s = (cnt_next_s == CNT_W'(BITSIZE));
    word_s      = {shift_r[BITSIZE-2:0], d_s};
  end

  // Frame tracking FSM with registered sample outputs and status strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_HUNT;
      cnt_r      <= '0;
      shift_r    <= '0;
      hold_r     <= '0;
      lr_prev_r  <= 1'b0;
      chan_r     <= 1'b0;
      left_ok_r  <= 1'b0;
      left_chan  <= '0;
      right_chan <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      if (rise_s) begin
        lr_prev_r <= lr_s;
        case (state_r)
          ST_HUNT: begin
            if (edge_s) begin
              state_r <= ST_SHIFT;
              cnt_r   <= '0;
              chan_r  <= lr_s;
            end
          end
          ST_SHIFT: begin
            // An edge here means the slot ended before a full word arrived.
            if (edge_s) begin
              frame_err <= 1'b1;
              left_ok_r <= 1'b0;
              cnt_r     <= '0;
              chan_r    <= lr_s;
            end else begin
              shift_r <= word_s;
              cnt_r   <= cnt_next_s;
              if (word_done_s) begin
                state_r <= ST_WAIT;
                if (!chan_r) begin
                  hold_r    <= word_s;
                  left_ok_r <= 1'b1;
                end else if (left_ok_r) begin
                  left_chan  <= hold_r;
                  right_chan <= word_s;
                  valid      <= 1'b1;
                  left_ok_r  <= 1'b0;
                end
              end
            end
          end
          ST_WAIT: begin
            if (edge_s) begin
              state_r <= ST_SHIFT;
              cnt_r   <= '0;
              chan_r  <= lr_s;
            end
          end
          default: begin
            state_r <= ST_HUNT;
            cnt_r   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Randomised I2S stream bench: a slot-level reference model fills a scoreboard
// queue, and a monitor compares every valid/frame_err strobe against it.
module tb_i2s_rx;

  localparam int BS = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          bclk;
  logic          lrclk;
  logic          sdata;
  logic [BS-1:0] left_chan;
  logic [BS-1:0] right_chan;
  logic          valid;
  logic          frame_err;

  always #5 clk = ~clk;

  i2s_rx #(.BITSIZE(BS)) dut (
    .clk        (clk),
    .reset      (reset),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .sdata      (sdata),
    .left_chan  (left_chan),
    .right_chan (right_chan),
    .valid      (valid),
    .frame_err  (frame_err)
  );

  typedef struct {
    bit            is_err;
    logic [BS-1:0] l;
    logic [BS-1:0] r;
    time           gap;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            checks = 0;
  int            errors = 0;
  time           last_rise_t = 0;
  time           last_valid_t = 0;
  logic [BS-1:0] last_l = '0;
  logic [BS-1:0] last_r = '0;

  // reference model state, one step per word-select slot
  bit            m_hunt;
  bit            m_active;
  bit            m_short;
  bit            m_prev;
  bit            m_left_ok;
  logic [BS-1:0] m_hold;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // monitor: every strobe must match the head of the scoreboard
  always @(negedge clk) begin
    if (reset) begin
      last_l = '0;
      last_r = '0;
    end else if (valid || frame_err) begin
      chk("valid_err_exclusive", 64'(valid & frame_err), 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: valid=%0b frame_err=%0b with nothing expected at t=%0t",
                 valid, frame_err, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("strobe_kind_is_err", 64'(frame_err), 64'(mon_e.is_err));
        // rise driven 3 after a posedge: sampled 7 later, acted 2 clk on, seen at the negedge
        chk("strobe_latency", 64'($time - last_rise_t), 64'd32);
        if (mon_e.is_err) begin
          chk("hold_left_on_err", 64'(left_chan), 64'(last_l));
          chk("hold_right_on_err", 64'(right_chan), 64'(last_r));
        end else begin
          chk("left_chan", 64'(left_chan), 64'(mon_e.l));
          chk("right_chan", 64'(right_chan), 64'(mon_e.r));
          if (mon_e.gap != 0)
            chk("valid_spacing", 64'($time - last_valid_t), 64'(mon_e.gap));
          last_l       = mon_e.l;
          last_r       = mon_e.r;
          last_valid_t = $time;
        end
      end
    end
  end

  task automatic send_bit(input bit lr, input bit d, input int half);
    lrclk = lr;
    sdata = d;
    #(half * 10);
    bclk = 1'b1;
    last_rise_t = $time;
    #(half * 10);
    bclk = 1'b0;
  endtask

  // One word-select slot of len bit clocks; the first is the I2S delay bit and
  // w supplies the following bits MSB first. The model predicts the slot's effect.
  task automatic send_run(input bit lr, input int len, input logic [31:0] w,
                          input int half, input time gap);
    logic [BS-1:0] wexp;
    bit            d;
    wexp = w[31:32-BS];
    if (lr != m_prev) begin
      if (m_hunt) begin
        m_hunt = 1'b0;
      end else if (m_active && m_short) begin
        exp_q.push_back('{is_err: 1'b1, l: '0, r: '0, gap: 0});
        m_left_ok = 1'b0;
      end
      m_active = 1'b1;
      m_short  = (len - 1) < BS;
      if (!m_short) begin
        if (lr == 1'b0) begin
          m_hold    = wexp;
          m_left_ok = 1'b1;
        end else if (m_left_ok) begin
          exp_q.push_back('{is_err: 1'b0, l: m_hold, r: wexp, gap: gap});
          m_left_ok = 1'b0;
        end
      end
    end
    m_prev = lr;
    for (int k = 0; k < len; k++) begin
      if (k >= 1 && k <= 32) d = w[32-k];
      else d = 1'($urandom_range(0, 1));
      send_bit(lr, d, half);
    end
  endtask

  task automatic apply_reset;
    @(posedge clk);
    #3;
    reset = 1'b1;
    bclk  = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_left_chan", 64'(left_chan), 64'd0);
    chk("reset_right_chan", 64'(right_chan), 64'd0);
    chk("reset_valid", 64'(valid), 64'd0);
    chk("reset_frame_err", 64'(frame_err), 64'd0);
    #1;
    reset     = 1'b0;
    m_hunt    = 1'b1;
    m_active  = 1'b0;
    m_short   = 1'b0;
    m_prev    = 1'b0;
    m_left_ok = 1'b0;
    m_hold    = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    bit lr;
    int len;
    reset = 1'b1;
    bclk  = 1'b0;
    lrclk = 1'b0;
    sdata = 1'b0;
    apply_reset();

    // sync frame, then a 16-bit pair in minimal slots
    send_run(1'b0, 17, $urandom(), 8, 0);
    send_run(1'b1, 17, $urandom(), 8, 0);
    send_run(1'b0, 17, 32'h1234_0000, 8, 0);
    send_run(1'b1, 17, 32'hABCD_0000, 8, 0);

    // wide slots: trailing bits ignored
    send_run(1'b0, 32, 32'h1234_FFFF, 8, 0);
    send_run(1'b1, 32, 32'h8000_0001, 8, 0);

    // good pair, broken pair with short right, good pair
    send_run(1'b0, 17, 32'h1111_0000, 8, 0);
    send_run(1'b1, 17, 32'h2222_0000, 8, 0);
    send_run(1'b0, 17, $urandom(), 8, 0);
    send_run(1'b1, 10, $urandom(), 8, 0);
    send_run(1'b0, 17, 32'h3333_0000, 8, 0);
    send_run(1'b1, 17, 32'h4444_0000, 8, 0);

    // slot of exactly BS clocks holds one bit too few
    send_run(1'b0, BS, $urandom(), 8, 0);
    send_run(1'b1, 17, $urandom(), 8, 0);

    // extremes at a fixed 64-BCLK frame period
    send_run(1'b0, 32, 32'h8000_0000, 8, 0);
    send_run(1'b1, 32, 32'h7FFF_0000, 8, 0);
    send_run(1'b0, 32, 32'hFFFF_0000, 8, 0);
    send_run(1'b1, 32, 32'h0000_0000, 8, 64 * 16 * 10);

    // random slots, occasionally short, at bit clocks from 4x to 16x
    lr = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 9) == 0) len = $urandom_range(1, BS);
      else len = $urandom_range(BS + 1, 36);
      send_run(lr, len, $urandom(), $urandom_range(2, 8), 0);
      lr = ~lr;
    end

    // reset in the middle of a left word
    send_run(1'b0, 6, $urandom(), 8, 0);
    apply_reset();
    send_run(1'b0, 11, $urandom(), 8, 0);
    send_run(1'b1, 17, $urandom(), 8, 0);
    send_run(1'b0, 17, $urandom(), 8, 0);
    send_run(1'b1, 17, $urandom(), 8, 0);

    // stream picked up mid right slot after reset
    apply_reset();
    send_run(1'b1, 20, $urandom(), 8, 0);
    send_run(1'b0, 17, $urandom(), 6, 0);
    send_run(1'b1, 17, $urandom(), 6, 0);

    repeat (100) @(posedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
